cordic_job_ctrl: RTL and testbench

AHB-Lite master-side job controller that shares the CORDIC APB slave (behind the AHB2APB bridge) between two requesters. Each requester hands over an (x, y) operand pair; the block arbitrates round-robin, then sequences three single AHB-Lite transfers through the bridge: write x, write y, read result. It returns the result word, or an error flag, to the winning requester. It sits between on-chip job sources and the bridge's AHB slave port, replacing bench-driven transfers.

---
 rtl/cordic_job_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_cordic_job_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_job_ctrl.sv
// cordic_job_ctrl: shares the CORDIC APB slave (reached through the AHB2APB
// bridge) between two job requesters. A round-robin grant latches one (x, y)
// pair, then three single AHB-Lite transfers are issued: write x, write y,
// read result. The result word or an error flag is returned to the requester.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for req_valid; grant and operand capture happen here
// AX    | address phase, write x to BASE+0
// DX    | data phase of x write, HWDATA = x
// AY    | address phase, write y to BASE+1
// DY    | data phase of y write, HWDATA = y
// AR    | address phase, read result from BASE+2
// DR    | data phase of result read, HRDATA sampled on completion
// RSP   | result/error held on rsp_* until rsp_ready
//
// Operand buses are flat: requester i owns bits [32*i +: 32] of req_x/req_y.
module cordic_job_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h8C00_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [1:0]  req_valid,
  input  logic [63:0] req_x,
  input  logic [63:0] req_y,
  output logic [1:0]  req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  output logic        HSEL,
  output logic        HREADYOUT_M,
  input  logic        HREADY,
  input  logic [1:0]  HRESP,
  input  logic [31:0] HRDATA,
  output logic [7:0]  done_cnt0,
  output logic [7:0]  done_cnt1,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {IDLE, AX, DX, AY, DY, AR, DR, RSP} state_t;

  state_t      state_q, state_d;
  logic [31:0] x_q, y_q;
  logic        id_q;
  logic        last_grant_q;
  logic        grant_id;
  logic        bus_err;
  logic        data_done;
  logic [31:0] haddr_d, hwdata_d;
  logic [1:0]  htrans_d;
  logic        hwrite_d, hsel_d, hreadyout_d;
  logic [3:0]  hprot_d;

  assign HSIZE   = 3'b010;
  assign HBURST  = 3'b000;
  assign rsp_id  = id_q;
  assign bus_err = (HRESP != 2'b00);
  assign data_done = HREADY && (state_q == DX || state_q == DY || state_q == DR);

  // Round-robin pick: on contention the requester not granted last wins.
  always_comb begin
    grant_id = 1'b0;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant_q;
      default: grant_id = 1'b0;
    endcase
  end

  // Next state, grant pulse, and bus values for the state being entered.
  always_comb begin
    state_d     = state_q;
    req_ready   = 2'b00;
    haddr_d     = 32'h0;
    htrans_d    = 2'b00;
    hwrite_d    = 1'b0;
    hprot_d     = 4'h0;
    hwdata_d    = 32'h0;
    hsel_d      = 1'b0;
    hreadyout_d = 1'b0;
    case (state_q)
      IDLE: if (req_valid != 2'b00) begin
              req_ready = grant_id ? 2'b10 : 2'b01;
              state_d   = AX;
            end
      AX:   if (HREADY) state_d = DX;
      DX:   if (HREADY) state_d = bus_err ? RSP : AY;
      AY:   if (HREADY) state_d = DY;
      DY:   if (HREADY) state_d = bus_err ? RSP : AR;
      AR:   if (HREADY) state_d = DR;
      DR:   if (HREADY) state_d = RSP;
      RSP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    case (state_d)
      AX, AY, AR: begin
        hsel_d      = 1'b1;
        hreadyout_d = 1'b1;
        htrans_d    = 2'b10;
        hprot_d     = 4'b0001;
        hwrite_d    = (state_d != AR);
        haddr_d     = (state_d == AX) ? BASE_ADDR :
                      (state_d == AY) ? BASE_ADDR + 32'd1 : BASE_ADDR + 32'd2;
      end
      DX, DY, DR: begin
        hsel_d      = 1'b1;
        hreadyout_d = 1'b1;
        hwdata_d    = (state_d == DX) ? x_q : (state_d == DY) ? y_q : 32'h0;
      end
      default: ;
    endcase
  end

  // State register and registered bus outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      HADDR       <= 32'h0;
      HTRANS      <= 2'b00;
      HWRITE      <= 1'b0;
      HPROT       <= 4'h0;
      HWDATA      <= 32'h0;
      HSEL        <= 1'b0;
      HREADYOUT_M <= 1'b0;
      rsp_valid   <= 1'b0;
    end else begin
      state_q     <= state_d;
      HADDR       <= haddr_d;
      HTRANS      <= htrans_d;
      HWRITE      <= hwrite_d;
      HPROT       <= hprot_d;
      HWDATA      <= hwdata_d;
      HSEL        <= hsel_d;
      HREADYOUT_M <= hreadyout_d;
      rsp_valid   <= (state_d == RSP);
    end
  end

  // Operand capture at grant, result capture at data-phase completion,
  // counters and round-robin history on response accept.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      x_q          <= 32'h0;
      y_q          <= 32'h0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_data     <= 32'h0;
      rsp_err      <= 1'b0;
      done_cnt0    <= 8'h0;
      done_cnt1    <= 8'h0;
      err_cnt      <= 8'h0;
    end else begin
      if (state_q == IDLE && req_valid != 2'b00) begin
        x_q  <= grant_id ? req_x[63:32] : req_x[31:0];
        y_q  <= grant_id ? req_y[63:32] : req_y[31:0];
        id_q <= grant_id;
      end
      if (data_done) begin
        if (bus_err) begin
          rsp_data <= 32'h0;
          rsp_err  <= 1'b1;
        end else if (state_q == DR) begin
          rsp_data <= HRDATA;
          rsp_err  <= 1'b0;
        end
      end
      if (state_q == RSP && rsp_ready) begin
        last_grant_q <= id_q;
        if (rsp_err)   err_cnt   <= err_cnt + 8'd1;
        else if (id_q) done_cnt1 <= done_cnt1 + 8'd1;
        else           done_cnt0 <= done_cnt0 + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cordic_job_ctrl.sv
// Bench for cordic_job_ctrl: a behavioural AHB bridge slave with configurable
// data-phase wait states and an error address, a table of single-job vectors,
// and hand-written sequences for arbitration, back-pressure and reset.
module tb_cordic_job_ctrl;

  localparam logic [31:0] BASE = 32'h8C00_0000;
  localparam logic [31:0] RKEY = 32'h5A5A_0F0F;

  logic        HCLK, HRESETn;
  logic [1:0]  req_valid, req_ready;
  logic [63:0] req_x, req_y;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic        HWRITE, HSEL, HREADYOUT_M, HREADY;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [7:0]  done_cnt0, done_cnt1, err_cnt;

  cordic_job_ctrl dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .HSEL(HSEL),
    .HREADYOUT_M(HREADYOUT_M), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .done_cnt0(done_cnt0), .done_cnt1(done_cnt1), .err_cnt(err_cnt)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // ---------------- bridge model ----------------
  logic        dphase, dwrite;
  logic [31:0] daddr, wr_x, wr_y, cur_x, cur_y, err_addr;
  logic        err_en;
  int          wcnt, wait_cfg, proto_bad;
  logic [32:0] alog[$];

  assign HREADY = !dphase || (wcnt == 0);
  assign HRESP  = (dphase && wcnt == 0 && err_en && daddr == err_addr) ? 2'b01 : 2'b00;
  assign HRDATA = (dphase && !dwrite && wcnt == 0) ? (wr_x ^ wr_y ^ RKEY) : 32'h0;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dphase <= 1'b0;
      dwrite <= 1'b0;
      daddr  <= 32'h0;
      wcnt   <= 0;
    end else begin
      if (dphase) begin
        if (HTRANS != 2'b00 || HADDR != 32'h0 || HWRITE || HPROT != 4'h0 || !HSEL || !HREADYOUT_M)
          proto_bad = proto_bad + 1;
        if (HWDATA != (dwrite ? ((daddr == BASE) ? cur_x : cur_y) : 32'h0))
          proto_bad = proto_bad + 1;
        if (wcnt > 0) wcnt <= wcnt - 1;
        else begin
          if (dwrite) begin
            if (daddr == BASE) wr_x <= HWDATA;
            else               wr_y <= HWDATA;
          end
          dphase <= 1'b0;
        end
      end
      if (HSEL && HTRANS == 2'b10 && HREADY) begin
        if (HPROT != 4'b0001 || HSIZE != 3'b010 || HBURST != 3'b000 || !HREADYOUT_M)
          proto_bad = proto_bad + 1;
        alog.push_back({HWRITE, HADDR});
        dphase <= 1'b1;
        daddr  <= HADDR;
        dwrite <= HWRITE;
        wcnt   <= wait_cfg;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int         n_cmp, n_bad;
  string      cur_tag;
  logic [7:0] exp_d0, exp_d1, exp_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h want %0h", cur_tag, name, act, exp);
    end
  endtask

  task automatic wait_grant(output bit ok, output int dly);
    ok = 1'b0; dly = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge HCLK);
      if (req_ready != 2'b00) begin ok = 1'b1; dly = i; break; end
    end
    if (!ok) chk("grant_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output bit ok, output int lat);
    ok = 1'b0; lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge HCLK);
      if (rsp_valid) begin ok = 1'b1; lat = i; break; end
    end
    if (!ok) chk("rsp_timeout", 0, 1);
  endtask

  task automatic accept(input bit drop_valid);
    @(posedge HCLK); #1;
    rsp_ready = 1'b1;
    if (drop_valid) req_valid = 2'b00;
    @(posedge HCLK); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic check_counters();
    chk("done_cnt0", done_cnt0, exp_d0);
    chk("done_cnt1", done_cnt1, exp_d1);
    chk("err_cnt", err_cnt, exp_e);
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] x;
    logic [31:0] y;
    int          waits;
    int          err_at;   // 0 none, 1 x write, 2 y write, 3 result read
    logic        exp_id;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v);
    bit ok; int dly, lat, steps;
    wait_cfg = v.waits;
    err_en   = (v.err_at != 0);
    err_addr = BASE + 32'(v.err_at) - 32'd1;
    cur_x = v.x; cur_y = v.y;
    alog.delete();
    proto_bad = 0;
    @(posedge HCLK); #1;
    req_x = v.exp_id ? {v.x, ~v.x} : {~v.x, v.x};
    req_y = v.exp_id ? {v.y, ~v.y} : {~v.y, v.y};
    req_valid = v.valid;
    wait_grant(ok, dly);
    if (!ok) begin req_valid = 2'b00; return; end
    chk("req_ready", req_ready, v.exp_id ? 2'b10 : 2'b01);
    @(posedge HCLK); #1;
    req_valid = 2'b00;
    wait_rsp(ok, lat);
    if (!ok) return;
    chk("latency", lat, v.exp_lat);
    chk("rsp_id", rsp_id, v.exp_id);
    chk("rsp_err", rsp_err, v.exp_err);
    chk("rsp_data", rsp_data, v.exp_err ? 32'h0 : (v.x ^ v.y ^ RKEY));
    steps = (v.err_at == 0) ? 3 : v.err_at;
    chk("xfer_count", alog.size(), steps);
    for (int i = 0; i < alog.size() && i < steps; i++)
      chk("xfer_addr", alog[i], {(i < 2) ? 1'b1 : 1'b0, BASE + 32'(i)});
    chk("bus_protocol", proto_bad, 0);
    accept(1'b0);
    if (v.exp_err) exp_e++;
    else if (v.exp_id) exp_d1++;
    else exp_d0++;
    @(negedge HCLK);
    chk("rsp_valid_drop", rsp_valid, 0);
    check_counters();
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[7];
  logic [31:0] rx[2], ry[2];

  initial begin
    bit ok; int dly, lat, bad_hold, spur;
    logic [31:0] saved;

    vecs[0] = '{2'b01, 32'h0038_0000, 32'h005C_0000, 0, 0, 1'b0, 7,  1'b0};
    vecs[1] = '{2'b10, 32'h1234_5678, 32'h8765_4321, 0, 0, 1'b1, 7,  1'b0};
    vecs[2] = '{2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, 3, 0, 1'b0, 16, 1'b0};
    vecs[3] = '{2'b10, 32'h0001_0000, 32'h0002_0000, 0, 2, 1'b1, 5,  1'b1};
    vecs[4] = '{2'b01, 32'hFFFF_0001, 32'h7FFF_FFFF, 0, 1, 1'b0, 3,  1'b1};
    vecs[5] = '{2'b10, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1, 3, 1'b1, 10, 1'b1};
    vecs[6] = '{2'b01, 32'h8000_0000, 32'h0000_0001, 2, 2, 1'b0, 9,  1'b1};

    n_cmp = 0; n_bad = 0;
    exp_d0 = 0; exp_d1 = 0; exp_e = 0;
    HRESETn = 1'b0; req_valid = 2'b00; req_x = '0; req_y = '0; rsp_ready = 1'b0;
    wait_cfg = 0; err_en = 1'b0; err_addr = '0; cur_x = '0; cur_y = '0;
    wr_x = '0; wr_y = '0; proto_bad = 0;

    cur_tag = "reset";
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("bus_idle", {HSEL, HREADYOUT_M, HTRANS, HWRITE, HPROT}, 0);
    chk("HADDR", HADDR, 0);
    chk("HWDATA", HWDATA, 0);
    chk("HSIZE_HBURST", {HSIZE, HBURST}, 6'b010_000);
    chk("rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, 0);
    check_counters();
    HRESETn = 1'b1;

    // Both requesters valid from reset: grants alternate starting with 0.
    cur_tag = "round_robin";
    rx[0] = 32'h0011_1111; ry[0] = 32'h0022_2222;
    rx[1] = 32'h0333_0000; ry[1] = 32'h0444_0004;
    @(posedge HCLK); #1;
    req_x = {rx[1], rx[0]}; req_y = {ry[1], ry[0]}; req_valid = 2'b11;
    proto_bad = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(ok, dly);
      if (!ok) break;
      chk("grant_order", req_ready, (k % 2) ? 2'b10 : 2'b01);
      if (k > 0) chk("grant_delay", dly, 0);
      cur_x = rx[k % 2]; cur_y = ry[k % 2];
      wait_rsp(ok, lat);
      if (!ok) break;
      chk("rsp_id", rsp_id, k % 2);
      chk("rsp_data", rsp_data, rx[k % 2] ^ ry[k % 2] ^ RKEY);
      if (k % 2) exp_d1++; else exp_d0++;
      accept(k == 3);
    end
    req_valid = 2'b00;
    @(negedge HCLK);
    chk("done_cnt0_two", done_cnt0, 8'd2);
    chk("done_cnt1_two", done_cnt1, 8'd2);
    chk("bus_protocol", proto_bad, 0);

    for (int i = 0; i < 7; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_vec(vecs[i]);
    end

    // Response held while rsp_ready low; a pending request must wait.
    cur_tag = "hold";
    wait_cfg = 0; err_en = 1'b0;
    rx[0] = 32'h0123_4567; ry[0] = 32'h0765_4321;
    rx[1] = 32'h0F0F_0000; ry[1] = 32'h0000_F0F0;
    cur_x = rx[0]; cur_y = ry[0];
    @(posedge HCLK); #1;
    req_x = {rx[1], rx[0]}; req_y = {ry[1], ry[0]}; req_valid = 2'b01;
    wait_grant(ok, dly);
    chk("req_ready", req_ready, 2'b01);
    @(posedge HCLK); #1;
    req_valid = 2'b10;
    wait_rsp(ok, lat);
    saved = rsp_data;
    chk("rsp_data", rsp_data, rx[0] ^ ry[0] ^ RKEY);
    bad_hold = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      if (rsp_valid !== 1'b1 || rsp_data !== saved || req_ready !== 2'b00) bad_hold++;
    end
    chk("held_stable", bad_hold, 0);
    exp_d0++;
    accept(1'b0);
    wait_grant(ok, dly);
    chk("next_grant", req_ready, 2'b10);
    chk("next_grant_delay", dly, 0);
    cur_x = rx[1]; cur_y = ry[1];
    @(posedge HCLK); #1;
    req_valid = 2'b00;
    wait_rsp(ok, lat);
    chk("rsp_id2", rsp_id, 1);
    chk("rsp_data2", rsp_data, rx[1] ^ ry[1] ^ RKEY);
    exp_d1++;
    accept(1'b0);
    @(negedge HCLK);
    check_counters();

    // Reset asserted while the y write is in its data phase.
    cur_tag = "reset_mid_job";
    cur_x = 32'h0055_0000; cur_y = 32'h0066_0000;
    @(posedge HCLK); #1;
    req_x = {32'h0, cur_x}; req_y = {32'h0, cur_y}; req_valid = 2'b01;
    wait_grant(ok, dly);
    @(posedge HCLK); #1;
    req_valid = 2'b00;
    repeat (4) @(negedge HCLK);
    chk("in_dy", {HSEL, HTRANS, HWDATA}, {1'b1, 2'b00, cur_y});
    #2 HRESETn = 1'b0;
    #1;
    chk("bus_idle", {HSEL, HREADYOUT_M, HTRANS, HWRITE, HPROT}, 0);
    chk("HADDR", HADDR, 0);
    chk("HWDATA", HWDATA, 0);
    chk("rsp_valid", rsp_valid, 0);
    exp_d0 = 0; exp_d1 = 0; exp_e = 0;
    check_counters();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    spur = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      if (rsp_valid !== 1'b0 || HSEL !== 1'b0) spur++;
    end
    chk("no_response", spur, 0);
    cur_tag = "after_reset";
    run_vec(vecs[1]);

    // Counter wrap: 257 completed jobs on requester 0 leaves done_cnt0 at 1.
    cur_tag = "wrap";
    for (int j = 0; j < 257; j++) run_vec(vecs[0]);
    chk("done_cnt0_wrapped", done_cnt0, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
